// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - request and instruction-memory write bundle for instr_encoder_loader
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [20:0]       imm;
  logic              last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, op_sel, rd, rs1, rs2, imm, last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op_sel, rd, rs1, rs2, imm, last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - RV32I instruction encoder feeding a FIFO-buffered imem loader
// Optional feature macro: ENC_NOP_PAD_EN (pad the session with NOPs to a 4-word boundary)
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ENC_NOP_PAD_EN
  localparam logic [1:0]  S_PAD = 2'd3;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`endif
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] PTR_WRAP = {1'b1, {PTR_W{1'b0}}};

  logic [1:0]        state;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_one;
  logic              last_seen;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              wr_fire;
  logic              session_end;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [ADDR_W-1:0] count_inc;
  logic [1:0]        unused_base_lsb;

  assign unused_base_lsb = base_addr[1:0];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == PTR_WRAP);
  assign fifo_one   = ((wr_ptr - rd_ptr) == PTR_ONE);

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (bus.op_sel)
      3'd0: enc_word = {7'b0, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      3'd1: enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
      3'd2: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                        bus.imm[4:1], bus.imm[11], 7'b1100011};
      3'd3: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, 7'b1101111};
      3'd4: enc_word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
      3'd5: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
      default: enc_legal = 1'b0;
    endcase
  end

  assign bus.in_ready = (state == S_LOAD) && !fifo_full && !last_seen;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && enc_legal;

  always_comb begin
    bus.imem_we    = 1'b0;
    bus.imem_wdata = 32'h0;
    if (state == S_LOAD && !fifo_empty) begin
      bus.imem_we    = 1'b1;
      bus.imem_wdata = mem[rd_ptr[PTR_W-1:0]];
    end
`ifdef ENC_NOP_PAD_EN
    if (state == S_PAD) begin
      bus.imem_we    = 1'b1;
      bus.imem_wdata = NOP;
    end
`endif
  end

  assign bus.imem_addr = imem_addr_q;
  assign wr_fire       = bus.imem_we && bus.imem_ready;
  assign pop           = wr_fire && (state == S_LOAD);
  assign count_inc     = count + {{(ADDR_W-1){1'b0}}, 1'b1};
  // last_seen blocks further accepts, so the FIFO only drains from here on
  assign session_end   = (state == S_LOAD) && last_seen && (fifo_empty || (pop && fifo_one));
  assign done          = (state == S_DONE);

`ifdef ENC_NOP_PAD_EN
  logic [ADDR_W-1:0] cnt_after;
  assign cnt_after = wr_fire ? count_inc : count;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_seen   <= 1'b0;
      imem_addr_q <= '0;
      err         <= 1'b0;
      count       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_fire) begin
        imem_addr_q <= imem_addr_q + ADDR_W'(4);
        count       <= count_inc;
      end
      if (accept && bus.last) last_seen <= 1'b1;
      if (accept && !enc_legal) err <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            imem_addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
            count       <= '0;
            err         <= 1'b0;
            last_seen   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
          end
        end
        S_LOAD: begin
          if (session_end) begin
`ifdef ENC_NOP_PAD_EN
            state <= (cnt_after[1:0] != 2'b00) ? S_PAD : S_DONE;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef ENC_NOP_PAD_EN
        S_PAD: begin
          if (wr_fire && count_inc[1:0] == 2'b00) state <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;
  localparam int ADDR_W = 10;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] count;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [ADDR_W-1:0] exp_addr;
  int sess_words;
  time last_wr_t;

  // entries 0..5 follow the encoding walk; unused fields carry junk that must not leak
  logic [2:0]  t_op  [7] = '{3'd1, 3'd0, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
  logic [4:0]  t_rd  [7] = '{5'd1, 5'd3, 5'd5, 5'd31, 5'd4, 5'd1, 5'd7};
  logic [4:0]  t_rs1 [7] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd1, 5'd3, 5'd1};
  logic [4:0]  t_rs2 [7] = '{5'd7, 5'd2, 5'd9, 5'd5, 5'd2, 5'd6, 5'd2};
  logic [20:0] t_imm [7] = '{21'd5, 21'h15555, 21'h1FF008, 21'h10000C, 21'd9, 21'd17, 21'd0};
  logic [31:0] t_word[7] = '{32'h00500093, 32'h002081B3, 32'h00812283, 32'h00512623,
                             32'h00208463, 32'h010000EF, 32'h00000000};

  always @(negedge clk) begin
    if (rst_n && bus.imem_we && bus.imem_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                   bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
        end
      end
      last_wr_t = $time;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time expired");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int idx);
    exp_t e;
    e.addr = exp_addr;
    e.data = t_word[idx];
    sb.push_back(e);
    exp_addr += ADDR_W'(4);
    sess_words++;
  endtask

  task automatic drive_req(input int idx, input logic lst);
    bus.op_sel   = t_op[idx];
    bus.rd       = t_rd[idx];
    bus.rs1      = t_rs1[idx];
    bus.rs2      = t_rs2[idx];
    bus.imm      = t_imm[idx];
    bus.last     = lst;
    bus.in_valid = 1'b1;
  endtask

  task automatic finish_session;
`ifdef ENC_NOP_PAD_EN
    exp_t e;
    while (sess_words % 4 != 0) begin
      e.addr = exp_addr;
      e.data = 32'h00000013;
      sb.push_back(e);
      exp_addr += ADDR_W'(4);
      sess_words++;
    end
`endif
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start      = 1'b0;
    exp_addr   = b & ~ADDR_W'(3);
    sess_words = 0;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL start_clear done=%b err=%b count=%0d required 0 0 0", done, err, count);
    end
  endtask

  task automatic send(input int idx, input logic lst);
    int n;
    drive_req(idx, lst);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL accept_timeout idx=%0d in_ready=%b required 1", idx, bus.in_ready);
    end else if (t_op[idx] < 3'd6) begin
      push_exp(idx);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic wait_done(input string name, output time done_t);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    done_t = $time;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout done=%b required 1", name, done);
    end
    checks++;
    if (count !== ADDR_W'(sess_words)) begin
      failures++;
      $display("FAIL %s_count count=%0d required %0d", name, count, sess_words);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes pending=%0d required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake in_ready=%b imem_we=%b required 0 0", bus.in_ready, bus.imem_we);
    end
    checks++;
    if (bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h data=%h required 0 0", bus.imem_addr, bus.imem_wdata);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL reset_status done=%b err=%b count=%0d required 0 0 0", done, err, count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet in_ready=%b done=%b required 0 0", bus.in_ready, done);
    end
  endtask

  task automatic test_encoding;
    time done_t;
    bus.imem_ready = 1'b1;
    do_start(10'h040);
    for (int i = 0; i < 6; i++) send(i, i == 5);
    finish_session;
    wait_done("encoding", done_t);
    checks++;
    if (done_t - last_wr_t != 10) begin
      failures++;
      $display("FAIL done_latency delay=%0t required 10", done_t - last_wr_t);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL encoding_err err=%b required 0", err);
    end
  endtask

  task automatic test_backpressure;
    int acc;
    int n;
    logic held;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0] h_data;
    time done_t;
    bus.imem_ready = 1'b0;
    do_start(10'h100);
    acc  = 0;
    held = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_req(acc, acc == 4);
      start     = (c == 5);
      base_addr = 10'h300;
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(acc);
        acc++;
      end
      if (bus.imem_we) begin
        if (!held) begin
          h_addr = bus.imem_addr;
          h_data = bus.imem_wdata;
          held   = 1'b1;
        end else begin
          checks++;
          if (bus.imem_addr !== h_addr || bus.imem_wdata !== h_data) begin
            failures++;
            $display("FAIL stall_hold addr=%h data=%h required addr=%h data=%h",
                     bus.imem_addr, bus.imem_wdata, h_addr, h_data);
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (acc != 4 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full_accepts accepted=%0d in_ready=%b required 4 0", acc, bus.in_ready);
    end
    checks++;
    if (held !== 1'b1 || h_addr !== 10'h100 || h_data !== t_word[0]) begin
      failures++;
      $display("FAIL stall_head we_seen=%b addr=%h data=%h required 1 100 %h", held, h_addr, h_data, t_word[0]);
    end
    bus.imem_ready = 1'b1;
    n = 0;
    while (acc < 5 && n < 50) begin
      drive_req(acc, acc == 4);
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(acc);
        acc++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
    checks++;
    if (acc != 5) begin
      failures++;
      $display("FAIL release_accepts accepted=%0d required 5", acc);
    end
    finish_session;
    wait_done("backpressure", done_t);
  endtask

  task automatic test_illegal;
    time done_t;
    do_start(10'h203);
    send(0, 1'b0);
    send(1, 1'b0);
    send(6, 1'b1);
    finish_session;
    wait_done("illegal", done_t);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_err err=%b required 1", err);
    end
  endtask

  task automatic test_wrap;
    time done_t;
    do_start(10'h3FC);
    send(2, 1'b0);
    send(3, 1'b1);
    finish_session;
    wait_done("wrap", done_t);
  endtask

  task automatic test_reset_mid;
    time done_t;
    bus.imem_ready = 1'b0;
    do_start(10'h080);
    for (int i = 0; i < 3; i++) send(i, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_we !== 1'b0 || count !== '0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset we=%b count=%0d done=%b in_ready=%b required 0 0 0 0",
               bus.imem_we, count, done, bus.in_ready);
    end
    sb.delete();
    bus.imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_start(10'h000);
    send(4, 1'b0);
    send(5, 1'b1);
    finish_session;
    wait_done("after_reset", done_t);
  endtask

`ifdef ENC_NOP_PAD_EN
  task automatic test_pad;
    time done_t;
    do_start(10'h000);
    for (int i = 0; i < 5; i++) send(i, i == 4);
    finish_session;
    wait_done("pad", done_t);
    checks++;
    if (count !== 10'd8) begin
      failures++;
      $display("FAIL pad_count count=%0d required 8", count);
    end
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    bus.in_valid   = 1'b0;
    bus.op_sel     = 3'd0;
    bus.rd         = 5'd0;
    bus.rs1        = 5'd0;
    bus.rs2        = 5'd0;
    bus.imm        = 21'd0;
    bus.last       = 1'b0;
    bus.imem_ready = 1'b0;
    exp_addr       = '0;
    sess_words     = 0;
    last_wr_t      = 0;
    test_reset;
    test_encoding;
    test_backpressure;
    test_illegal;
    test_wrap;
    test_reset_mid;
`ifdef ENC_NOP_PAD_EN
    test_pad;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
